gat_bram_load_ctrl: RTL and testbench
=====================================

# gat_bram_load_ctrl

Parametrised host-to-core BRAM load controller for the GAT accelerator. It takes NUM_CH byte-addressed 32-bit host BRAM write ports, converts them to word-addressed, width-truncated core BRAM writes, and counts the words landed per channel against programmed depths. When every channel is loaded it pulses a start to the core, tracks completion, and returns a registered readback path for the result BRAM. It sits between the block-design BRAM controllers and `gat_top`, replacing the thin slicing wrapper and the externally driven per-buffer load-done bits.

## Interface
- TOP_WIDTH, 32, host data width
- NUM_CH, 4, number of load channels
- DATA_W, 20, core-side write data width per channel (low bits of host data)
- ADDR_W, 18, core-side word address width; host byte address is ADDR_W+2
- RD_ADDR_W, 16, core-side readback word address width
- RD_W, 32, readback data width
- RD_PIPE, 1, readback register stages, 0..2

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  pulse: latch cfg_depth, clear counters/errors, enter LOAD
- cfg_depth  in  NUM_CH*ADDR_W  expected words per channel (0 = channel unused)
- host_din  in  NUM_CH*TOP_WIDTH  host write data
- host_ena  in  NUM_CH  host enable
- host_wea  in  NUM_CH  host write strobe
- host_addra  in  NUM_CH*(ADDR_W+2)  host byte address
- core_din  out  NUM_CH*DATA_W  registered core data
- core_ena  out  NUM_CH  registered core enable
- core_wea  out  NUM_CH  registered core write strobe
- core_addra  out  NUM_CH*ADDR_W  registered core word address
- core_start  out  1  one-cycle start pulse
- core_ready  in  1  core done level
- gat_ready  out  1  high in DONE
- load_done  out  NUM_CH  per-channel count reached depth
- load_err  out  NUM_CH  sticky per-channel address error
- status  out  TOP_WIDTH  {state[2:0], load_err, load_done}, zero-extended
- host_rd_addrb  in  RD_ADDR_W+2  host byte read address
- core_rd_addrb  out  RD_ADDR_W  host_rd_addrb[RD_ADDR_W+1:2], combinational
- core_rd_dout  in  RD_W  core result BRAM data
- host_rd_dout  out  RD_W  core_rd_dout after RD_PIPE registers

## Operation
- States: IDLE(0), LOAD(1), ARM(2), RUN(3), DONE(4).
- IDLE: writes forwarded, not counted. cfg_valid -> LOAD.
- Accepted write on channel c: host_ena&host_wea. Forwarded as core_addra = addr[ADDR_W+1:2], core_din = din[DATA_W-1:0]. In LOAD it increments cnt[c] (ADDR_W+1 bits, saturating at depth).
- Duplicate addresses count twice; counting is by writes, not unique addresses.
- load_done[c] = (cnt[c] == depth[c]); depth 0 is done immediately.
- LOAD -> ARM when all load_done high. ARM lasts exactly one cycle with core_start=1, then RUN.
- RUN -> DONE when core_ready=1. DONE holds gat_ready=1. cfg_valid in any state -> LOAD.
- cfg_valid coincident with a write: the write is forwarded but not counted. Counters clear and the new depth is latched.
- With GAT_BRAM_ADDR_CHECK_EN, a write with addr[1:0]!=0 or word addr >= depth[c] is dropped:
  - core_ena/wea stay 0 for that write
  - cnt is not incremented
  - load_err[c] sets and stays set until cfg_valid or reset
- Reads are unaffected by state.

## Timing
- Reset: all outputs 0; state IDLE; cnt, depth, err, readback pipeline cleared. Reset mid-load aborts without further core writes.
- core_* write outputs lag the host by 1 cycle. Reads (ena&!wea) are forwarded the same way, with core_wea=0.
- load_done rises the cycle after the edge that captures the final write.
- core_start is asserted 2 cycles after that final write edge (LOAD->ARM transition).
- gat_ready rises 1 cycle after core_ready is sampled high in RUN.
- host_rd_dout latency = RD_PIPE cycles on top of the core BRAM read latency.

## Configuration
- GAT_BRAM_ADDR_CHECK_EN defined: alignment/range checking and sticky load_err as above.
- GAT_BRAM_ADDR_CHECK_EN undefined: every write is forwarded and counted, and load_err is tied to 0.

## Structure
- Shared gat_pkg: state enum (gat_ld_state_e), state encodings, status field offsets.
- Sub-module gat_bram_ch_port, one per channel via generate. It contains:
  - the address/data slice and 1-cycle register
  - the counter and depth register
  - the error check
- Top holds the FSM, the status mux and the readback pipeline.

## Test plan
- NUM_CH=4, depth={8,4,0,2}; write 8/4/0/2 aligned words -> load_done=4'hF. core_start pulses once, 2 cycles after the last write; status[2:0]=2 during the pulse.
- Ch0 write at byte addr 0x14, data 0xABCDE123 -> next cycle core_addra[0]=5, core_din[0]=0xDE123, core_wea[0]=1.
- Checks on, ch1 depth 4: write to byte 0x10 and then to 0x06 -> no core write either time, load_err=4'b0010, cnt unchanged. With the macro off, the same writes are forwarded and counted.
- cfg_valid on the same cycle as a ch0 write in LOAD -> the write appears on core_* but cnt[0]=0 afterwards.
- In RUN, raise core_ready -> gat_ready=1 next cycle. cfg_valid then -> state LOAD, gat_ready=0, load_done clears except zero-depth channels.
- RD_PIPE=2, host_rd_addrb=0x40 -> core_rd_addrb=0x10; core_rd_dout 0x12345678 appears on host_rd_dout 2 cycles later. Assert rst_n low mid-load -> all outputs 0 immediately.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types for the GAT BRAM load controller.
// State encoding and status word field offsets.
package gat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } gat_ld_state_e;

  localparam int ST_W          = 3;
  localparam int STAT_DONE_LSB = 0;

  function automatic int stat_err_lsb(input int n);
    return n;
  endfunction

  function automatic int stat_state_lsb(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/gat_bram_ch_port.sv
// One host-to-core BRAM load channel: slice, register, count.
// Optional GAT_BRAM_ADDR_CHECK_EN drops misaligned/out-of-range writes.
module gat_bram_ch_port
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic                 count_en,
  input  logic [ADDR_W-1:0]    cfg_depth,
  input  logic [TOP_WIDTH-1:0] host_din,
  input  logic                 host_ena,
  input  logic                 host_wea,
  input  logic [ADDR_W+1:0]    host_addra,
  output logic [DATA_W-1:0]    core_din,
  output logic                 core_ena,
  output logic                 core_wea,
  output logic [ADDR_W-1:0]    core_addra,
  output logic                 load_done,
  output logic                 load_err
);

  logic [ADDR_W-1:0] depth_q;
  logic [ADDR_W:0]   cnt_q;
  logic              cfg_seen;
  logic              wr;
  logic              drop;
  logic              inc;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_bits;

  assign word_addr   = host_addra[ADDR_W+1:2];
  assign wr          = host_ena & host_wea;
  assign unused_bits = ^{host_din[TOP_WIDTH-1:DATA_W], host_addra[1:0]};

`ifdef GAT_BRAM_ADDR_CHECK_EN
  logic err_q;

  assign drop = wr & count_en &
                ((host_addra[1:0] != 2'b00) | (word_addr >= depth_q));
  assign load_err = err_q;

  // sticky error until the next configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (cfg_valid)
      err_q <= 1'b0;
    else if (drop)
      err_q <= 1'b1;
  end
`else
  assign drop     = 1'b0;
  assign load_err = 1'b0;
`endif

  assign inc = count_en & wr & ~drop & (cnt_q < {1'b0, depth_q});

  // forward the host access one cycle later as a word access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_din   <= '0;
      core_ena   <= 1'b0;
      core_wea   <= 1'b0;
      core_addra <= '0;
    end else begin
      core_din   <= host_din[DATA_W-1:0];
      core_addra <= word_addr;
      core_ena   <= host_ena & ~drop;
      core_wea   <= host_wea & ~drop;
    end
  end

  // depth latch, saturating write counter and registered done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q   <= '0;
      cnt_q     <= '0;
      cfg_seen  <= 1'b0;
      load_done <= 1'b0;
    end else if (cfg_valid) begin
      depth_q   <= cfg_depth;
      cnt_q     <= '0;
      cfg_seen  <= 1'b1;
      load_done <= 1'b0;
    end else begin
      if (inc)
        cnt_q <= cnt_q + 1'b1;
      load_done <= cfg_seen & (cnt_q == {1'b0, depth_q});
    end
  end

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// GAT host-to-core BRAM load controller: channels, FSM, readback.
// GAT_BRAM_ADDR_CHECK_EN enables write address checking.
module gat_bram_load_ctrl
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 18,
  parameter int RD_ADDR_W = 16,
  parameter int RD_W      = 32,
  parameter int RD_PIPE   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  input  logic [NUM_CH*ADDR_W-1:0]    cfg_depth,
  input  logic [NUM_CH*TOP_WIDTH-1:0] host_din,
  input  logic [NUM_CH-1:0]           host_ena,
  input  logic [NUM_CH-1:0]           host_wea,
  input  logic [NUM_CH*(ADDR_W+2)-1:0] host_addra,
  output logic [NUM_CH*DATA_W-1:0]    core_din,
  output logic [NUM_CH-1:0]           core_ena,
  output logic [NUM_CH-1:0]           core_wea,
  output logic [NUM_CH*ADDR_W-1:0]    core_addra,
  output logic                        core_start,
  input  logic                        core_ready,
  output logic                        gat_ready,
  output logic [NUM_CH-1:0]           load_done,
  output logic [NUM_CH-1:0]           load_err,
  output logic [TOP_WIDTH-1:0]        status,
  input  logic [RD_ADDR_W+1:0]        host_rd_addrb,
  output logic [RD_ADDR_W-1:0]        core_rd_addrb,
  input  logic [RD_W-1:0]             core_rd_dout,
  output logic [RD_W-1:0]             host_rd_dout
);

  localparam int ERR_LSB = stat_err_lsb(NUM_CH);
  localparam int ST_LSB  = stat_state_lsb(NUM_CH);

  gat_ld_state_e state_q;
  gat_ld_state_e state_d;
  logic          count_en;
  logic          unused_rd;

  assign count_en = (state_q == ST_LOAD) & ~cfg_valid;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_bram_ch_port #(
      .TOP_WIDTH (TOP_WIDTH),
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .count_en   (count_en),
      .cfg_depth  (cfg_depth[c*ADDR_W +: ADDR_W]),
      .host_din   (host_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .host_ena   (host_ena[c]),
      .host_wea   (host_wea[c]),
      .host_addra (host_addra[c*(ADDR_W+2) +: ADDR_W+2]),
      .core_din   (core_din[c*DATA_W +: DATA_W]),
      .core_ena   (core_ena[c]),
      .core_wea   (core_wea[c]),
      .core_addra (core_addra[c*ADDR_W +: ADDR_W]),
      .load_done  (load_done[c]),
      .load_err   (load_err[c])
    );
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // next state and Moore outputs; cfg_valid restarts from any state
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    gat_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_LOAD: if (&load_done) state_d = ST_ARM;
      ST_ARM: begin
        core_start = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN:  if (core_ready) state_d = ST_DONE;
      ST_DONE: gat_ready = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (cfg_valid)
      state_d = ST_LOAD;
  end

  // status word: {state, load_err, load_done}, zero-extended
  always_comb begin
    status = '0;
    status[STAT_DONE_LSB +: NUM_CH] = load_done;
    status[ERR_LSB +: NUM_CH]       = load_err;
    status[ST_LSB +: ST_W]          = state_q;
  end

  assign core_rd_addrb = host_rd_addrb[RD_ADDR_W+1:2];
  assign unused_rd     = ^host_rd_addrb[1:0];

  if (RD_PIPE == 0) begin : g_rd_comb
    assign host_rd_dout = core_rd_dout;
  end else begin : g_rd_pipe
    logic [RD_W-1:0] pipe_q [RD_PIPE];

    // readback delay line
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_PIPE; i++)
          pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= core_rd_dout;
        for (int i = 1; i < RD_PIPE; i++)
          pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign host_rd_dout = pipe_q[RD_PIPE-1];
  end

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Bench for gat_bram_load_ctrl: random loads vs a count model.
// Follows GAT_BRAM_ADDR_CHECK_EN when defined at compile time.
module tb_gat_bram_load_ctrl;

  localparam int TOP_WIDTH = 32;
  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 20;
  localparam int ADDR_W    = 18;
  localparam int RD_ADDR_W = 16;
  localparam int RD_W      = 32;
  localparam int RD_PIPE   = 2;
  localparam int AW2       = ADDR_W + 2;
`ifdef GAT_BRAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        cfg_valid;
  logic [NUM_CH*ADDR_W-1:0]    cfg_depth;
  logic [NUM_CH*TOP_WIDTH-1:0] host_din;
  logic [NUM_CH-1:0]           host_ena;
  logic [NUM_CH-1:0]           host_wea;
  logic [NUM_CH*AW2-1:0]       host_addra;
  logic [NUM_CH*DATA_W-1:0]    core_din;
  logic [NUM_CH-1:0]           core_ena;
  logic [NUM_CH-1:0]           core_wea;
  logic [NUM_CH*ADDR_W-1:0]    core_addra;
  logic                        core_start;
  logic                        core_ready;
  logic                        gat_ready;
  logic [NUM_CH-1:0]           load_done;
  logic [NUM_CH-1:0]           load_err;
  logic [TOP_WIDTH-1:0]        status;
  logic [RD_ADDR_W+1:0]        host_rd_addrb;
  logic [RD_ADDR_W-1:0]        core_rd_addrb;
  logic [RD_W-1:0]             core_rd_dout;
  logic [RD_W-1:0]             host_rd_dout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gat_bram_load_ctrl #(
    .TOP_WIDTH (TOP_WIDTH),
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .RD_ADDR_W (RD_ADDR_W),
    .RD_W      (RD_W),
    .RD_PIPE   (RD_PIPE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_depth     (cfg_depth),
    .host_din      (host_din),
    .host_ena      (host_ena),
    .host_wea      (host_wea),
    .host_addra    (host_addra),
    .core_din      (core_din),
    .core_ena      (core_ena),
    .core_wea      (core_wea),
    .core_addra    (core_addra),
    .core_start    (core_start),
    .core_ready    (core_ready),
    .gat_ready     (gat_ready),
    .load_done     (load_done),
    .load_err      (load_err),
    .status        (status),
    .host_rd_addrb (host_rd_addrb),
    .core_rd_addrb (core_rd_addrb),
    .core_rd_dout  (core_rd_dout),
    .host_rd_dout  (host_rd_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    host_ena   = '0;
    host_wea   = '0;
    host_din   = '0;
    host_addra = '0;
    cfg_valid  = 1'b0;
  endtask

  task automatic host_wr(input int c, input logic [AW2-1:0] a,
                         input logic [31:0] d, input logic we);
    host_ena[c] = 1'b1;
    host_wea[c] = we;
    host_addra[c*AW2 +: AW2] = a;
    host_din[c*TOP_WIDTH +: TOP_WIDTH] = d;
  endtask

  task automatic set_cfg(input int d0, input int d1,
                         input int d2, input int d3);
    logic [ADDR_W-1:0] v;
    cfg_valid = 1'b1;
    v = d0[ADDR_W-1:0]; cfg_depth[0*ADDR_W +: ADDR_W] = v;
    v = d1[ADDR_W-1:0]; cfg_depth[1*ADDR_W +: ADDR_W] = v;
    v = d2[ADDR_W-1:0]; cfg_depth[2*ADDR_W +: ADDR_W] = v;
    v = d3[ADDR_W-1:0]; cfg_depth[3*ADDR_W +: ADDR_W] = v;
  endtask

  function automatic logic [ADDR_W-1:0] c_addr(input int c);
    return core_addra[c*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] c_din(input int c);
    return core_din[c*DATA_W +: DATA_W];
  endfunction

  task automatic test_reset();
    host_idle();
    cfg_depth     = '0;
    core_ready    = 1'b0;
    core_rd_dout  = 32'hCAFE_0001;
    host_rd_addrb = '0;
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({core_ena, core_wea, core_start, gat_ready} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got=%0h exp=0",
               {core_ena, core_wea, core_start, gat_ready});
    end
    checks++;
    if ({core_din, core_addra} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%0h exp=0", {core_din, core_addra});
    end
    checks++;
    if ({load_done, load_err, status, host_rd_dout} !== '0) begin
      failures++;
      $display("FAIL reset_status got=%0h exp=0",
               {load_done, load_err, status, host_rd_dout});
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (load_done !== 4'h0 || status !== 32'h0) begin
      failures++;
      $display("FAIL idle_after_reset done=%0h status=%0h exp=0 0",
               load_done, status);
    end
  endtask

  task automatic test_forward();
    logic            e_ena [NUM_CH];
    logic            e_wea [NUM_CH];
    logic [31:0]     e_adr [NUM_CH];
    logic [31:0]     e_din [NUM_CH];
    logic [AW2-1:0]  a;
    logic [31:0]     d;
    host_idle();
    host_wr(0, 'h14, 32'hABCDE123, 1'b1);
    step();
    host_idle();
    checks++;
    if (c_addr(0) !== 18'd5 || c_din(0) !== 20'hDE123 ||
        core_wea[0] !== 1'b1 || core_ena[0] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_directed addr=%0h din=%0h wea=%0b exp=5 de123 1",
               c_addr(0), c_din(0), core_wea[0]);
    end
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        a = AW2'($urandom);
        d = $urandom;
        e_ena[c] = 1'($urandom_range(0, 1));
        e_wea[c] = 1'($urandom_range(0, 1));
        e_adr[c] = 32'(a) / 4;
        e_din[c] = d % (32'd1 << DATA_W);
        host_ena[c] = e_ena[c];
        host_wea[c] = e_wea[c];
        host_addra[c*AW2 +: AW2] = a;
        host_din[c*TOP_WIDTH +: TOP_WIDTH] = d;
      end
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (core_ena[c] !== e_ena[c] ||
            core_wea[c] !== (e_ena[c] & e_wea[c] | (~e_ena[c] & e_wea[c])) ||
            32'(c_addr(c)) !== e_adr[c] || 32'(c_din(c)) !== e_din[c]) begin
          failures++;
          $display("FAIL fwd_rand ch%0d got=%0b%0b/%0h/%0h exp=%0b%0b/%0h/%0h",
                   c, core_ena[c], core_wea[c], c_addr(c), c_din(c),
                   e_ena[c], e_wea[c], e_adr[c], e_din[c]);
        end
      end
    end
    host_idle();
    step();
    checks++;
    if (status !== 32'h0) begin
      failures++;
      $display("FAIL idle_no_count status=%0h exp=0", status);
    end
  endtask

  task automatic test_load();
    int          dep [NUM_CH];
    int          cnt [NUM_CH];
    logic        e_ena [NUM_CH];
    logic [31:0] e_adr [NUM_CH];
    logic [31:0] e_din [NUM_CH];
    logic [3:0]  d_before;
    int          left;
    int          starts;
    int          w;
    logic [31:0] d;
    dep[0] = 8; dep[1] = 4; dep[2] = 0; dep[3] = 2;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    set_cfg(8, 4, 0, 2);
    step();
    host_idle();
    left = 14;
    for (int it = 0; it < 400 && left > 0; it++) begin
      for (int c = 0; c < NUM_CH; c++)
        d_before[c] = (cnt[c] == dep[c]);
      for (int c = 0; c < NUM_CH; c++) begin
        e_ena[c] = 1'b0;
        if (cnt[c] < dep[c] && $urandom_range(0, 1) == 1) begin
          w = $urandom_range(0, dep[c] - 1);
          d = $urandom;
          host_wr(c, AW2'(w * 4), d, 1'b1);
          e_ena[c] = 1'b1;
          e_adr[c] = 32'(w);
          e_din[c] = d % (32'd1 << DATA_W);
          cnt[c]++;
          left--;
        end
      end
      step();
      host_idle();
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (core_ena[c] !== e_ena[c] || core_wea[c] !== e_ena[c] ||
            (e_ena[c] && (32'(c_addr(c)) !== e_adr[c] ||
                          32'(c_din(c)) !== e_din[c]))) begin
          failures++;
          $display("FAIL load_fwd ch%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h",
                   c, core_ena[c], c_addr(c), c_din(c),
                   e_ena[c], e_adr[c], e_din[c]);
        end
      end
      checks++;
      if (load_done !== d_before) begin
        failures++;
        $display("FAIL load_done_prog got=%0h exp=%0h", load_done, d_before);
      end
    end
    checks++;
    if (left != 0) begin
      failures++;
      $display("FAIL load_budget got=%0d exp=0", left);
    end
    step();
    checks++;
    if (load_done !== 4'hF || core_start !== 1'b0 || status[10:8] !== 3'd1) begin
      failures++;
      $display("FAIL load_done_all done=%0h start=%0b st=%0d exp=f 0 1",
               load_done, core_start, status[10:8]);
    end
    step();
    starts = int'(core_start);
    checks++;
    if (core_start !== 1'b1 || status !== 32'h0000_020F) begin
      failures++;
      $display("FAIL start_pulse start=%0b status=%0h exp=1 20f",
               core_start, status);
    end
    step();
    checks++;
    if (core_start !== 1'b0 || status[10:8] !== 3'd3) begin
      failures++;
      $display("FAIL run_entry start=%0b st=%0d exp=0 3",
               core_start, status[10:8]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      starts += int'(core_start);
    end
    checks++;
    if (starts != 1) begin
      failures++;
      $display("FAIL start_once got=%0d exp=1", starts);
    end
  endtask

  task automatic test_run_done();
    int hi = 0;
    core_ready = 1'b0;
    for (int i = 0; i < int'($urandom_range(2, 5)); i++) begin
      step();
      hi += int'(gat_ready);
    end
    checks++;
    if (hi != 0 || status[10:8] !== 3'd3) begin
      failures++;
      $display("FAIL run_wait ready_cnt=%0d st=%0d exp=0 3", hi, status[10:8]);
    end
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    checks++;
    if (gat_ready !== 1'b1 || status[10:8] !== 3'd4) begin
      failures++;
      $display("FAIL gat_ready ready=%0b st=%0d exp=1 4",
               gat_ready, status[10:8]);
    end
    step();
    checks++;
    if (gat_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_hold got=%0b exp=1", gat_ready);
    end
    set_cfg(3, 0, 5, 0);
    step();
    host_idle();
    checks++;
    if (status[10:8] !== 3'd1 || gat_ready !== 1'b0 || load_done !== 4'h0) begin
      failures++;
      $display("FAIL recfg st=%0d ready=%0b done=%0h exp=1 0 0",
               status[10:8], gat_ready, load_done);
    end
    step();
    checks++;
    if (load_done !== 4'b1010) begin
      failures++;
      $display("FAIL zero_depth_done got=%0h exp=a", load_done);
    end
  endtask

  task automatic test_cfg_collide();
    logic [31:0] d;
    d = $urandom;
    set_cfg(1, 0, 0, 0);
    host_wr(0, '0, d, 1'b1);
    step();
    host_idle();
    checks++;
    if (core_ena[0] !== 1'b1 || core_wea[0] !== 1'b1 ||
        32'(c_din(0)) !== d % (32'd1 << DATA_W)) begin
      failures++;
      $display("FAIL collide_fwd got=%0b%0b/%0h exp=11/%0h",
               core_ena[0], core_wea[0], c_din(0), d % (32'd1 << DATA_W));
    end
    repeat (2) step();
    checks++;
    if (load_done !== 4'b1110 || status[10:8] !== 3'd1) begin
      failures++;
      $display("FAIL collide_uncounted done=%0h st=%0d exp=e 1",
               load_done, status[10:8]);
    end
    host_wr(0, '0, $urandom, 1'b1);
    step();
    host_idle();
    step();
    checks++;
    if (load_done !== 4'hF) begin
      failures++;
      $display("FAIL collide_recount got=%0h exp=f", load_done);
    end
    repeat (2) step();
  endtask

  task automatic test_addr_check();
    logic e_fwd;
    int   nvalid;
    e_fwd  = ~CHK;
    nvalid = CHK ? 4 : 2;
    set_cfg(0, 4, 0, 0);
    step();
    host_idle();
    host_wr(1, 'h10, $urandom, 1'b1);
    step();
    host_idle();
    checks++;
    if (core_ena[1] !== e_fwd || core_wea[1] !== e_fwd) begin
      failures++;
      $display("FAIL chk_range got=%0b%0b exp=%0b%0b",
               core_ena[1], core_wea[1], e_fwd, e_fwd);
    end
    host_wr(1, 'h06, $urandom, 1'b1);
    step();
    host_idle();
    checks++;
    if (core_ena[1] !== e_fwd || core_wea[1] !== e_fwd) begin
      failures++;
      $display("FAIL chk_align got=%0b%0b exp=%0b%0b",
               core_ena[1], core_wea[1], e_fwd, e_fwd);
    end
    step();
    checks++;
    if (load_err !== (CHK ? 4'b0010 : 4'b0000) || load_done !== 4'b1101) begin
      failures++;
      $display("FAIL chk_err err=%0h done=%0h exp=%0h d",
               load_err, load_done, CHK ? 4'b0010 : 4'b0000);
    end
    for (int i = 0; i < nvalid - 1; i++) begin
      host_wr(1, AW2'(i * 4), $urandom, 1'b1);
      step();
    end
    host_idle();
    step();
    checks++;
    if (load_done[1] !== 1'b0) begin
      failures++;
      $display("FAIL chk_cnt_unchanged got=%0b exp=0", load_done[1]);
    end
    host_wr(1, AW2'((nvalid - 1) * 4), $urandom, 1'b1);
    step();
    host_idle();
    step();
    checks++;
    if (load_done !== 4'hF || load_err !== (CHK ? 4'b0010 : 4'b0000)) begin
      failures++;
      $display("FAIL chk_complete done=%0h err=%0h", load_done, load_err);
    end
  endtask

  task automatic test_readback();
    logic [RD_W-1:0]      q[$];
    logic [RD_W-1:0]      v;
    logic [RD_ADDR_W+1:0] a;
    int                   bad = 0;
    host_rd_addrb = 'h40;
    #1;
    checks++;
    if (core_rd_addrb !== 16'h10) begin
      failures++;
      $display("FAIL rd_addr got=%0h exp=10", core_rd_addrb);
    end
    for (int i = 0; i < 8; i++) begin
      a = (RD_ADDR_W + 2)'($urandom);
      host_rd_addrb = a;
      #1;
      if (32'(core_rd_addrb) !== 32'(a) / 4) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rd_addr_rand bad=%0d exp=0", bad);
    end
    for (int i = 0; i < 12; i++) begin
      v = (i == 0) ? 32'h12345678 : $urandom;
      core_rd_dout = v;
      q.push_back(v);
      step();
      if (q.size() >= 2) begin
        checks++;
        if (host_rd_dout !== q[q.size()-2]) begin
          failures++;
          $display("FAIL rd_pipe got=%0h exp=%0h",
                   host_rd_dout, q[q.size()-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    set_cfg(8, 8, 8, 8);
    step();
    host_idle();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        host_wr(c, AW2'(i * 4), $urandom, 1'b1);
      step();
    end
    for (int c = 0; c < NUM_CH; c++)
      host_wr(c, AW2'(8), $urandom, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({core_ena, core_wea, core_din, core_addra} !== '0 ||
        {core_start, gat_ready, load_done, load_err} !== '0 ||
        status !== '0 || host_rd_dout !== '0) begin
      failures++;
      $display("FAIL rst_mid ena=%0h st=%0h rd=%0h exp=0 0 0",
               core_ena, status, host_rd_dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (core_ena !== '0 || core_wea !== '0) begin
      failures++;
      $display("FAIL rst_hold ena=%0h wea=%0h exp=0 0", core_ena, core_wea);
    end
    host_idle();
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (status !== 32'h0) begin
      failures++;
      $display("FAIL rst_idle got=%0h exp=0", status);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_load();
    test_run_done();
    test_cfg_collide();
    test_addr_check();
    test_readback();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
